// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline control blocks.
//   - ResultSrc encodings used by the E-stage result mux
//   - forwarding mux select encodings for ForwardAE/ForwardBE
//   - state encoding of the multi-cycle MDU tracking FSM
package rv_pipe_pkg;

    // E-stage result select encodings
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    // Operand forwarding mux selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // MDU tracking FSM: a single MDU can hold at most one op
    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, marking a
// destination whose value is still being produced by the out-of-order MDU.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   set_en, set_idx     mark set_idx pending (MDU op handed over this cycle)
//   clr_en, clr_idx     clear clr_idx (MDU result written this cycle)
//   clr_all             clear every bit (watchdog recovery)
//   rd_a/b/c_idx        three read addresses (D-stage RS1, RS2, RD)
//   hit_a/b/c           registered pending bit for each read address
// x0 is never tracked: its bit is forced low and reads of index 0 return 0.
// Reads return the registered state only, so a register is released the
// cycle after its clear, when the regfile already holds the result.
module hazard_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic              clr_all,
    input  logic [REG_AW-1:0] rd_a_idx,
    input  logic [REG_AW-1:0] rd_b_idx,
    input  logic [REG_AW-1:0] rd_c_idx,
    output logic              hit_a,
    output logic              hit_b,
    output logic              hit_c
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;

    // Next-state of the pending bits: clear-all dominates, then set beats clear
    always_comb begin
        sb_d = sb_q;
        if (clr_all) begin
            sb_d = {NUM_REGS{1'b0}};
        end else begin
            if (clr_en) begin
                sb_d[clr_idx] = 1'b0;
            end else begin
                sb_d = sb_d;
            end
            // Applied after the clear so a same-index set/clear leaves the bit set
            if (set_en && (set_idx != {REG_AW{1'b0}})) begin
                sb_d[set_idx] = 1'b1;
            end else begin
                sb_d = sb_d;
            end
        end
        sb_d[0] = 1'b0;
    end

    // Pending-bit storage
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= {NUM_REGS{1'b0}};
        end else begin
            sb_q <= sb_d;
        end
    end

    // Read ports; bit 0 is held low so index 0 never reports a hit
    always_comb begin
        hit_a = sb_q[rd_a_idx];
        hit_b = sb_q[rd_b_idx];
        hit_c = sb_q[rd_c_idx];
    end

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage RISC-V pipeline with an out-of-order MDU.
// Provides M/W operand forwarding, load-use stall, branch/jump flush, a
// register scoreboard for MDU destinations (RAW and WAW) and a tracking FSM
// with watchdog for the single multi-cycle MDU.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   RegWriteM/W, RD_M, RD_W        M/W writeback info for forwarding
//   RD_E, Rs1_E, Rs2_E, ResultSrcE E-stage registers and result select
//   RS1_D, RS2_D, RD_D, RegWriteD  D-stage registers and write enable
//   MduD                           D-stage instruction is an MDU op
//   BranchE, ZeroE, JumpE          control-flow resolution in E
//   MduIssueE                      MDU op in E handed to the MDU this cycle
//   mdu_done, mdu_rd               MDU writeback pulse and its destination
//   ForwardAE/BE                   E-stage operand mux selects
//   StallF, StallD, FlushD, FlushE pipeline controls
//   mdu_busy                       an MDU op is outstanding (registered)
//   mdu_timeout                    one-cycle watchdog expiry pulse (registered)
module hazard_unit_sb
    import rv_pipe_pkg::*;
#(
    parameter int         REG_AW   = 5,
    parameter logic [1:0] LOAD_SRC = RES_LOAD,
    parameter int         MDU_TMO  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RS1_D,
    input  logic [REG_AW-1:0] RS2_D,
    input  logic [REG_AW-1:0] RD_D,
    input  logic              RegWriteD,
    input  logic              MduD,
    input  logic [1:0]        ResultSrcE,
    input  logic              BranchE,
    input  logic              ZeroE,
    input  logic              JumpE,
    input  logic              MduIssueE,
    input  logic              mdu_done,
    input  logic [REG_AW-1:0] mdu_rd,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              mdu_busy,
    output logic              mdu_timeout
);

    localparam int                WD_W      = $clog2(MDU_TMO + 1);
    localparam logic [WD_W-1:0]   WDOG_LAST = WD_W'(MDU_TMO - 1);
    localparam logic [REG_AW-1:0] X0        = {REG_AW{1'b0}};

    mdu_state_e      state_q, state_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;
    logic            clr_all_s;

    logic hit_rs1_s, hit_rs2_s, hit_rd_s;
    logic lw_stall_s, sb_stall_s, st_stall_s, taken_s, stall_any_s;

    // M stage is younger than W, so its result wins when both match
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != X0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != X0) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (MduIssueE),
        .set_idx  (RD_E),
        .clr_en   (mdu_done),
        .clr_idx  (mdu_rd),
        .clr_all  (clr_all_s),
        .rd_a_idx (RS1_D),
        .rd_b_idx (RS2_D),
        .rd_c_idx (RD_D),
        .hit_a    (hit_rs1_s),
        .hit_b    (hit_rs2_s),
        .hit_c    (hit_rd_s)
    );

    // MDU FSM and watchdog next-state; a completion in the final watchdog
    // cycle counts as normal completion rather than a timeout
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
        clr_all_s = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (MduIssueE) begin
                    state_d = MDU_BUSY;
                    wdog_d  = {WD_W{1'b0}};
                end else begin
                    wdog_d  = {WD_W{1'b0}};
                end
            end
            MDU_BUSY: begin
                if (mdu_done) begin
                    // Back-to-back issue re-enters BUSY with a fresh watchdog
                    state_d = MduIssueE ? MDU_BUSY : MDU_IDLE;
                    wdog_d  = {WD_W{1'b0}};
                end else if (wdog_q == WDOG_LAST) begin
                    state_d   = MDU_IDLE;
                    wdog_d    = {WD_W{1'b0}};
                    timeout_d = 1'b1;
                    clr_all_s = 1'b1;
                end else begin
                    // An issue without a completion here is a protocol error and is ignored
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            default: begin
                state_d = MDU_IDLE;
                wdog_d  = {WD_W{1'b0}};
            end
        endcase
    end

    // MDU FSM state, watchdog counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MDU_IDLE;
            wdog_q    <= {WD_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // Forwarding selects and stall/flush generation
    always_comb begin
        ForwardAE = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
        ForwardBE = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);

        lw_stall_s = (ResultSrcE == LOAD_SRC) && (RD_E != X0) &&
                     ((RD_E == RS1_D) || (RD_E == RS2_D));
        sb_stall_s = hit_rs1_s | hit_rs2_s | (RegWriteD & hit_rd_s);
        // The MDU accepts a new op in the same cycle the old one retires
        st_stall_s = MduD && (state_q == MDU_BUSY) && !mdu_done;
        taken_s    = (BranchE && ZeroE) || JumpE;

        stall_any_s = lw_stall_s | sb_stall_s | st_stall_s;
        // A taken branch discards the D instruction anyway, so stalling it is pointless
        StallF = stall_any_s & !taken_s;
        StallD = stall_any_s & !taken_s;
        FlushD = taken_s;
        FlushE = taken_s | stall_any_s;

        mdu_busy    = (state_q == MDU_BUSY);
        mdu_timeout = timeout_q;
    end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed self-checking bench for hazard_unit_sb (REG_AW=5, MDU_TMO=40).
module tb_hazard_unit_sb;

    logic       clk;
    logic       rst;
    logic       RegWriteM, RegWriteW, RegWriteD, MduD;
    logic [4:0] RD_M, RD_W, RD_E, Rs1_E, Rs2_E, RS1_D, RS2_D, RD_D, mdu_rd;
    logic [1:0] ResultSrcE;
    logic       BranchE, ZeroE, JumpE, MduIssueE, mdu_done;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE, mdu_busy, mdu_timeout;

    int n_cmp;
    int n_err;

    hazard_unit_sb #(
        .REG_AW   (5),
        .LOAD_SRC (2'b01),
        .MDU_TMO  (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .RD_M        (RD_M),
        .RD_W        (RD_W),
        .RD_E        (RD_E),
        .Rs1_E       (Rs1_E),
        .Rs2_E       (Rs2_E),
        .RS1_D       (RS1_D),
        .RS2_D       (RS2_D),
        .RD_D        (RD_D),
        .RegWriteD   (RegWriteD),
        .MduD        (MduD),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .ZeroE       (ZeroE),
        .JumpE       (JumpE),
        .MduIssueE   (MduIssueE),
        .mdu_done    (mdu_done),
        .mdu_rd      (mdu_rd),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .mdu_busy    (mdu_busy),
        .mdu_timeout (mdu_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        RegWriteM = 1'b0; RegWriteW = 1'b0; RegWriteD = 1'b0; MduD = 1'b0;
        RD_M = 5'd0; RD_W = 5'd0; RD_E = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
        RS1_D = 5'd0; RS2_D = 5'd0; RD_D = 5'd0; mdu_rd = 5'd0;
        ResultSrcE = 2'b00; BranchE = 1'b0; ZeroE = 1'b0; JumpE = 1'b0;
        MduIssueE = 1'b0; mdu_done = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_busy", {1'b0, mdu_busy}, 2'b00);
        chk("rst_tmo", {1'b0, mdu_timeout}, 2'b00);
        chk("rst_stall", {StallF, StallD}, 2'b00);
        chk("rst_flush", {FlushD, FlushE}, 2'b00);
        chk("rst_fwd", ForwardAE, 2'b00);
        rst = 1'b0;
        tick();

        // Forwarding: M beats W
        RegWriteM = 1'b1; RD_M = 5'd5; RegWriteW = 1'b1; RD_W = 5'd5;
        Rs1_E = 5'd5; Rs2_E = 5'd5;
        #1;
        chk("fwd_a_m", ForwardAE, 2'b10);
        chk("fwd_b_m", ForwardBE, 2'b10);
        RegWriteM = 1'b0;
        #1;
        chk("fwd_a_w", ForwardAE, 2'b01);
        // x0 never forwarded
        RegWriteM = 1'b1; RD_M = 5'd0; RD_W = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd3;
        #1;
        chk("fwd_a_x0", ForwardAE, 2'b00);
        chk("fwd_b_none", ForwardBE, 2'b00);
        RD_W = 5'd3;
        #1;
        chk("fwd_b_w", ForwardBE, 2'b01);
        idle_inputs();

        // Load-use
        ResultSrcE = 2'b01; RD_E = 5'd6; RS1_D = 5'd6; RS2_D = 5'd1; RD_D = 5'd7; RegWriteD = 1'b1;
        #1;
        chk("lw_stall", {StallF, StallD}, 2'b11);
        chk("lw_flush", {FlushD, FlushE}, 2'b01);
        RS1_D = 5'd1; RS2_D = 5'd6;
        #1;
        chk("lw_stall_rs2", {StallF, StallD}, 2'b11);
        ResultSrcE = 2'b00;
        #1;
        chk("alu_no_stall", {StallD, FlushE}, 2'b00);
        ResultSrcE = 2'b01; RD_E = 5'd0; RS2_D = 5'd0;
        #1;
        chk("lw_x0_no_stall", {StallD, FlushE}, 2'b00);
        // Taken branch overrides a load-use stall
        RD_E = 5'd6; RS2_D = 5'd6; BranchE = 1'b1; ZeroE = 1'b1;
        #1;
        chk("br_over_stall", {StallF, StallD}, 2'b00);
        chk("br_flush", {FlushD, FlushE}, 2'b11);
        idle_inputs();
        BranchE = 1'b1; ZeroE = 1'b0;
        #1;
        chk("br_not_taken", {FlushD, FlushE}, 2'b00);
        BranchE = 1'b0; JumpE = 1'b1;
        #1;
        chk("jump_flush", {FlushD, FlushE}, 2'b11);
        idle_inputs();

        // div x8 issues
        MduIssueE = 1'b1; RD_E = 5'd8;
        tick();
        idle_inputs();
        #1;
        chk("div_busy", {1'b0, mdu_busy}, 2'b01);
        RS1_D = 5'd8;
        #1;
        chk("raw_stall", {StallF, StallD}, 2'b11);
        chk("raw_flushE", {FlushD, FlushE}, 2'b01);
        RS1_D = 5'd9;
        #1;
        chk("x9_free", {StallF, StallD}, 2'b00);
        RS1_D = 5'd0; RD_D = 5'd8; RegWriteD = 1'b1;
        #1;
        chk("waw_stall", {1'b0, StallD}, 2'b01);
        RegWriteD = 1'b0;
        #1;
        chk("rd_no_write", {1'b0, StallD}, 2'b00);
        MduD = 1'b1; RD_D = 5'd9; RegWriteD = 1'b1;
        #1;
        chk("struct_stall", {1'b0, StallD}, 2'b01);
        // Completion cycle: structural stall released, RAW not yet
        mdu_done = 1'b1; mdu_rd = 5'd8;
        #1;
        chk("struct_release", {1'b0, StallD}, 2'b00);
        MduD = 1'b0; RegWriteD = 1'b0; RS2_D = 5'd8;
        #1;
        chk("raw_no_readthru", {1'b0, StallD}, 2'b01);
        tick();
        mdu_done = 1'b0;
        #1;
        chk("raw_released", {1'b0, StallD}, 2'b00);
        chk("div_idle", {1'b0, mdu_busy}, 2'b00);
        idle_inputs();

        // Back-to-back on the same register, then watchdog expiry
        MduIssueE = 1'b1; RD_E = 5'd8;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        mdu_done = 1'b1; mdu_rd = 5'd8; MduIssueE = 1'b1; RD_E = 5'd8;
        tick();
        idle_inputs();
        RS1_D = 5'd8;
        #1;
        chk("b2b_busy", {1'b0, mdu_busy}, 2'b01);
        chk("b2b_set_wins", {1'b0, StallD}, 2'b01);
        for (int i = 0; i < 39; i++) tick();
        chk("tmo_early", {mdu_busy, mdu_timeout}, 2'b10);
        tick();
        chk("tmo_pulse", {mdu_busy, mdu_timeout}, 2'b01);
        chk("tmo_sb_clear", {1'b0, StallD}, 2'b00);
        tick();
        chk("tmo_one_shot", {mdu_busy, mdu_timeout}, 2'b00);
        idle_inputs();

        // Reset in the middle of an MDU op
        MduIssueE = 1'b1; RD_E = 5'd10;
        tick();
        idle_inputs();
        RS2_D = 5'd10;
        #1;
        chk("pre_rst_stall", {mdu_busy, StallD}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_clear", {mdu_busy, StallD}, 2'b00);
        chk("midrst_tmo", {1'b0, mdu_timeout}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
